// File: rtl/pe_acc_pipe.sv
// Pipelined PE product-sum: registered adder tree plus packet accumulator.
// Define PE_ACC_SAT_EN to saturate the accumulator add instead of wrapping.
module pe_acc_pipe #(
  parameter int LANES = 32,
  parameter int IN_W  = 32,
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*IN_W-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      acc_result,
  output logic [CNT_W-1:0]      out_count
);

  localparam int L  = $clog2(LANES);
  localparam int SW = IN_W + L;
  localparam int TW = LANES * SW;

  logic                    en;
  logic [TW-1:0]           lv0;
  logic [TW-1:0]           lv [1:L];
  logic [L:1]              vld;
  logic [L:1]              lst;
  logic signed [SW-1:0]    top;
  logic signed [ACC_W-1:0] beat;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic                    in_pkt;

  // Pairwise lane sums; each element keeps the full SW width.
  function automatic logic [TW-1:0] pair_sum(
    input logic [TW-1:0] v
  );
    logic [TW-1:0] r;
    r = '0;
    for (int j = 0; j < LANES / 2; j++) begin
      r[j*SW +: SW] = v[2*j*SW +: SW]
                    + v[(2*j+1)*SW +: SW];
    end
    return r;
  endfunction

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  always_comb begin
    lv0 = '0;
    for (int j = 0; j < LANES; j++) begin
      lv0[j*SW +: SW] =
        SW'(signed'(in_data[j*IN_W +: IN_W]));
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      lv[1] <= pair_sum(lv0);
      for (int i = 2; i <= L; i++) begin
        lv[i] <= pair_sum(lv[i-1]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      lst <= '0;
    end else if (en) begin
      vld[1] <= in_valid;
      lst[1] <= in_last;
      for (int i = 2; i <= L; i++) begin
        vld[i] <= vld[i-1];
        lst[i] <= lst[i-1];
      end
    end
  end

  assign top  = lv[L][SW-1:0];
  assign beat = ACC_W'(top);

`ifdef PE_ACC_SAT_EN
  logic [ACC_W:0] wide;

  always_comb begin
    wide = {acc[ACC_W-1], acc}
         + {beat[ACC_W-1], beat};
    acc_sum = wide[ACC_W-1:0];
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      acc_sum = wide[ACC_W]
        ? {1'b1, {(ACC_W-1){1'b0}}}
        : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign acc_sum = acc + beat;
`endif

  assign acc_nxt = in_pkt ? acc_sum : beat;
  assign cnt_nxt = in_pkt ? cnt + CNT_W'(1)
                          : CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      in_pkt     <= 1'b0;
      out_valid  <= 1'b0;
      acc_result <= '0;
      out_count  <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (en && vld[L]) begin
        if (lst[L]) begin
          acc_result <= acc_nxt;
          out_count  <= cnt_nxt;
          out_valid  <= 1'b1;
          acc        <= '0;
          cnt        <= '0;
          in_pkt     <= 1'b0;
        end else begin
          acc    <= acc_nxt;
          cnt    <= cnt_nxt;
          in_pkt <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_acc_pipe.sv
// Directed bench for pe_acc_pipe: latency, signed sums, stalls, reset.
// Second instance (ACC_W=40) covers wrap or PE_ACC_SAT_EN saturation.
module tb_pe_acc_pipe;

  localparam int LANES = 32;
  localparam int IN_W  = 32;
  localparam int DW    = LANES * IN_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid;
  logic          in_valid2;
  logic          in_last;
  logic          out_ready;
  logic          out_ready2;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          in_ready2;
  logic          out_valid;
  logic          out_valid2;
  logic [47:0]   acc_result;
  logic [39:0]   acc_result2;
  logic [15:0]   out_count;
  logic [15:0]   out_count2;

  int errors = 0;
  int checks = 0;

  pe_acc_pipe #(
    .LANES(LANES), .IN_W(IN_W),
    .ACC_W(48), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc_result(acc_result), .out_count(out_count)
  );

  pe_acc_pipe #(
    .LANES(LANES), .IN_W(IN_W),
    .ACC_W(40), .CNT_W(16)
  ) dut40 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .acc_result(acc_result2), .out_count(out_count2)
  );

  function automatic logic [DW-1:0] fill(
    input logic [IN_W-1:0] v
  );
    logic [DW-1:0] d;
    for (int j = 0; j < LANES; j++) d[j*IN_W +: IN_W] = v;
    return d;
  endfunction

  function automatic logic [DW-1:0] lane0(
    input logic [IN_W-1:0] v
  );
    logic [DW-1:0] d;
    d = '0;
    d[IN_W-1:0] = v;
    return d;
  endfunction

  task automatic send(input logic [DW-1:0] d,
                      input logic last);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '1;
  endtask

  task automatic wait_out(output int n);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        n = i;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_count !== 16'd0
        || acc_result !== 48'd0)
      begin
      errors++;
      $display("FAIL reset: valid=%b acc=%h cnt=%0d, want 0/0/0",
               out_valid, acc_result, out_count);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_latency;
    int n;
    out_ready = 1'b1;
    in_data   = fill(32'd1);
    in_last   = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '1;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL latency: got %0d cycles want 6", n);
    end
    checks++;
    if (acc_result !== 48'd32 || out_count !== 16'd1) begin
      errors++;
      $display("FAIL ones: acc=%0d cnt=%0d want 32/1",
               acc_result, out_count);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_clear: got %b want 0", out_valid);
    end
  endtask

  task automatic test_signed;
    logic [DW-1:0] d;
    logic [IN_W-1:0] v;
    int n;
    for (int j = 0; j < LANES; j++) begin
      v = IN_W'(j - 16);
      d[j*IN_W +: IN_W] = v;
    end
    send(d, 1'b1);
    wait_out(n);
    checks++;
    if (n < 0 || acc_result !== 48'hFFFF_FFFF_FFF0
        || out_count !== 16'd1) begin
      errors++;
      $display("FAIL signed: acc=%h cnt=%0d want fffffffffff0/1",
               acc_result, out_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_multi_beat;
    int n;
    for (int b = 0; b < 4; b++) send(fill(32'h7FFF_FFFF), b == 3);
    wait_out(n);
    checks++;
    if (n < 0 || acc_result !== 48'h3F_FFFF_FF80) begin
      errors++;
      $display("FAIL multi_acc: got %h want 3fffffff80",
               acc_result);
    end
    checks++;
    if (out_count !== 16'd4) begin
      errors++;
      $display("FAIL multi_cnt: got %0d want 4", out_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_gaps;
    int n;
    send(lane0(32'd1), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    send(lane0(32'd2), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    send(lane0(32'd3), 1'b1);
    wait_out(n);
    checks++;
    if (n < 0 || acc_result !== 48'd6 || out_count !== 16'd3) begin
      errors++;
      $display("FAIL gaps: acc=%0d cnt=%0d want 6/3",
               acc_result, out_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int n;
    out_ready = 1'b0;
    send(lane0(32'd10), 1'b1);
    send(lane0(32'd20), 1'b1);
    wait_out(n);
    checks++;
    if (n < 0 || acc_result !== 48'd10 || out_count !== 16'd1) begin
      errors++;
      $display("FAIL bp_first: acc=%0d cnt=%0d want 10/1",
               acc_result, out_count);
    end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || acc_result !== 48'd10
          || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: c=%0d v=%b acc=%0d rdy=%b want 1/10/0",
                 c, out_valid, acc_result, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || acc_result !== 48'd20
        || out_count !== 16'd1) begin
      errors++;
      $display("FAIL bp_second: v=%b acc=%0d cnt=%0d want 1/20/1",
               out_valid, acc_result, out_count);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    int extra;
    out_ready = 1'b1;
    send(fill(32'd1), 1'b0);
    send(fill(32'd1), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || acc_result !== 48'd0
        || out_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_rst: v=%b acc=%0d cnt=%0d want 0/0/0",
               out_valid, acc_result, out_count);
    end
    rst = 1'b0;
    send(lane0(32'd5), 1'b1);
    wait_out(n);
    checks++;
    if (n < 0 || acc_result !== 48'd5 || out_count !== 16'd1) begin
      errors++;
      $display("FAIL mid_new: acc=%0d cnt=%0d want 5/1",
               acc_result, out_count);
    end
    extra = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL mid_extra: got %0d results want 0", extra);
    end
  endtask

  task automatic test_acc_limit;
    logic [63:0] t;
    logic [39:0] exp_acc;
    int n;
`ifdef PE_ACC_SAT_EN
    t = 64'd0;
    exp_acc = 40'h7F_FFFF_FFFF;
`else
    t = 64'd9600 * 64'd2147483647;
    exp_acc = t[39:0];
`endif
    out_ready2 = 1'b1;
    in_data    = fill(32'h7FFF_FFFF);
    in_valid2  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_last = (i == 299);
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0;
    in_last   = 1'b0;
    n = -1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid2) begin
        n = i;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (n < 0 || acc_result2 !== exp_acc) begin
      errors++;
      $display("FAIL acc40: got %h want %h (v=%b)",
               acc_result2, exp_acc, out_valid2);
    end
    checks++;
    if (out_count2 !== 16'd300) begin
      errors++;
      $display("FAIL cnt40: got %0d want 300", out_count2);
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_valid2  = 1'b0;
    in_last    = 1'b0;
    out_ready  = 1'b0;
    out_ready2 = 1'b0;
    in_data    = '0;
    test_reset;
    test_latency;
    test_signed;
    test_multi_beat;
    test_gaps;
    test_back_to_back;
    test_reset_mid;
    test_acc_limit;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

endmodule
